// File: rtl/rob_marker_tap.sv
// Commit-port tap: finds INFO marker instructions on every ROB commit lane and queues
// them as sequenced events for the sync monitor, tracking testcase phase and drops.
module rob_marker_tap #(
    parameter int unsigned LANES = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SEQ_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [LANES-1:0]      commit_valid,
    input  logic [LANES*32-1:0]   commit_inst,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [3:0]            evt_code,
    output logic [1:0]            evt_lane,
    output logic [SEQ_W-1:0]      evt_seq,
    output logic [3:0]            phase,
    output logic                  sim_exit,
    output logic                  overflow,
    output logic [15:0]           drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [3:0]       code;
        logic [1:0]       lane;
        logic [SEQ_W-1:0] seq;
    } evt_t;

    evt_t              mem_q [DEPTH];
    evt_t              mem_d [DEPTH];
    evt_t              head_q, head_d;
    logic              evt_valid_q, evt_valid_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [3:0]        phase_q, phase_d;
    logic              sim_exit_q, sim_exit_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic [LANES-1:0]  hit;
    logic [3:0]        hit_code [LANES];
    logic              pop;
    logic [SUM_W-1:0]  free_slots;
    logic [SUM_W-1:0]  n_wr;
    logic [SUM_W-1:0]  n_drop;
    logic [16:0]       drop_sum;

    // Per-lane marker decode: ADDI-style encoding with a 4-bit code in [23:20].
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            hit_code[i] = commit_inst[32*i+20 +: 4];
            hit[i]      = commit_valid[i]
                       && (commit_inst[32*i +: 20] == 20'h02013)
                       && (commit_inst[32*i+24 +: 8] == 8'h00)
                       && (hit_code[i] != 4'hF);
        end
    end

    // Enqueue in lane order against the slots left after this cycle's pop; the
    // next head is taken from the post-write image so outputs stay registered.
    always_comb begin
        mem_d      = mem_q;
        phase_d    = phase_q;
        n_wr       = '0;
        n_drop     = '0;
        pop        = evt_valid_q && evt_ready;
        free_slots = SUM_W'(DEPTH) - SUM_W'(count_q) + SUM_W'(pop);

        for (int i = 0; i < LANES; i++) begin
            if (hit[i]) begin
                if (n_wr < free_slots) begin
                    mem_d[PTR_W'(wr_ptr_q + PTR_W'(n_wr))] =
                        '{code: hit_code[i], lane: 2'(i), seq: seq_q + SEQ_W'(n_wr)};
                    if (!hit_code[i][0] && (hit_code[i] <= 4'hC)) begin
                        phase_d = hit_code[i];
                    end else if (hit_code[i][0] && (hit_code[i] <= 4'hD)
                                 && (phase_d == hit_code[i] - 4'h1)) begin
                        phase_d = 4'hF;
                    end
                    n_wr = n_wr + SUM_W'(1);
                end else begin
                    n_drop = n_drop + SUM_W'(1);
                end
            end
        end

        wr_ptr_d    = wr_ptr_q + PTR_W'(n_wr);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        count_d     = count_q - CNT_W'(pop) + CNT_W'(n_wr);
        seq_d       = seq_q + SEQ_W'(n_wr);
        drop_sum    = 17'(drop_cnt_q) + 17'(n_drop);
        drop_cnt_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow_d  = overflow_q || (n_drop != '0);
        sim_exit_d  = sim_exit_q || (pop && (head_q.code == 4'hE));
        evt_valid_d = (count_d != '0);
        head_d      = evt_valid_d ? mem_d[rd_ptr_d] : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q      <= '0;
            evt_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            seq_q       <= '0;
            phase_q     <= 4'hF;
            sim_exit_q  <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            head_q      <= head_d;
            evt_valid_q <= evt_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            seq_q       <= seq_d;
            phase_q     <= phase_d;
            sim_exit_q  <= sim_exit_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_code  = head_q.code;
    assign evt_lane  = head_q.lane;
    assign evt_seq   = head_q.seq;
    assign phase     = phase_q;
    assign sim_exit  = sim_exit_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_rob_marker_tap.sv
// Directed bench for rob_marker_tap (LANES=2, DEPTH=8) with hand-computed expectations.
module tb_rob_marker_tap;

    logic        clock;
    logic        reset;
    logic [1:0]  commit_valid;
    logic [63:0] commit_inst;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_code;
    logic [1:0]  evt_lane;
    logic [31:0] evt_seq;
    logic [3:0]  phase;
    logic        sim_exit;
    logic        overflow;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    rob_marker_tap #(.LANES(2), .DEPTH(8), .SEQ_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_inst  (commit_inst),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_lane     (evt_lane),
        .evt_seq      (evt_seq),
        .phase        (phase),
        .sim_exit     (sim_exit),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1);
        commit_valid = v;
        commit_inst  = {i1, i0};
    endtask

    task automatic do_reset;
        reset     = 1'b0;
        evt_ready = 1'b0;
        drive(2'b00, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        do_reset();

        // Reset state
        check("rst_valid",    64'(evt_valid), 64'h0);
        check("rst_code",     64'(evt_code),  64'h0);
        check("rst_lane",     64'(evt_lane),  64'h0);
        check("rst_seq",      64'(evt_seq),   64'h0);
        check("rst_phase",    64'(phase),     64'hF);
        check("rst_sim_exit", 64'(sim_exit),  64'h0);
        check("rst_overflow", 64'(overflow),  64'h0);
        check("rst_drop",     64'(drop_cnt),  64'h0);

        // Single START marker on lane 0, visible one cycle later
        drive(2'b01, 32'h00402013, 32'h0);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        check("t1_valid", 64'(evt_valid), 64'h1);
        check("t1_code",  64'(evt_code),  64'h4);
        check("t1_lane",  64'(evt_lane),  64'h0);
        check("t1_seq",   64'(evt_seq),   64'h0);
        check("t1_phase", 64'(phase),     64'h4);
        tick();
        check("t1_hold_seq", 64'(evt_seq), 64'h0);
        evt_ready = 1'b1;
        tick();
        check("t1_popped", 64'(evt_valid), 64'h0);

        // Two lanes same cycle: START 0 then END 1 closes the phase
        do_reset();
        evt_ready = 1'b1;
        drive(2'b11, 32'h00002013, 32'h00102013);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        check("t2_e0_valid", 64'(evt_valid), 64'h1);
        check("t2_e0_code",  64'(evt_code),  64'h0);
        check("t2_e0_seq",   64'(evt_seq),   64'h0);
        check("t2_phase",    64'(phase),     64'hF);
        tick();
        check("t2_e1_valid", 64'(evt_valid), 64'h1);
        check("t2_e1_code",  64'(evt_code),  64'h1);
        check("t2_e1_lane",  64'(evt_lane),  64'h1);
        check("t2_e1_seq",   64'(evt_seq),   64'h1);
        tick();
        check("t2_empty", 64'(evt_valid), 64'h0);

        // Nine markers into eight slots with the monitor stalled
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(2'b01, 32'h00202013, 32'h0);
            tick();
        end
        check("t3_overflow", 64'(overflow), 64'h1);
        check("t3_drop",     64'(drop_cnt), 64'h1);
        check("t3_head_seq", 64'(evt_seq),  64'h0);
        // Full FIFO with a same-cycle pop accepts the new hit
        drive(2'b01, 32'h00402013, 32'h0);
        evt_ready = 1'b1;
        tick();
        drive(2'b00, 32'h0, 32'h0);
        check("t4_drop",     64'(drop_cnt), 64'h1);
        check("t4_head_seq", 64'(evt_seq),  64'h1);
        check("t4_phase",    64'(phase),    64'h4);
        for (int s = 2; s <= 8; s++) begin
            tick();
            check($sformatf("t4_seq%0d", s), 64'(evt_seq), 64'(s));
        end
        check("t4_last_code", 64'(evt_code), 64'h4);
        tick();
        check("t4_empty", 64'(evt_valid), 64'h0);

        // Non-markers: code F, nonzero upper byte, plain ADDI, invalid lane
        do_reset();
        evt_ready = 1'b1;
        drive(2'b11, 32'h00f02013, 32'h01002013);
        tick();
        check("t5_codeF_upper", 64'(evt_valid), 64'h0);
        drive(2'b01, 32'h00000013, 32'h0);
        tick();
        check("t5_nop", 64'(evt_valid), 64'h0);
        drive(2'b00, 32'h00402013, 32'h00402013);
        tick();
        check("t5_not_valid", 64'(evt_valid), 64'h0);
        check("t5_phase",     64'(phase),     64'hF);

        // SIM_EXIT behind three events, then reset mid-queue
        do_reset();
        drive(2'b11, 32'h00002013, 32'h00102013);
        tick();
        drive(2'b11, 32'h00202013, 32'h00e02013);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        check("t6_phase", 64'(phase), 64'h2);
        evt_ready = 1'b1;
        tick();
        check("t6_exit_p1", 64'(sim_exit), 64'h0);
        tick();
        tick();
        check("t6_head_E",  64'(evt_code), 64'hE);
        check("t6_head_sq", 64'(evt_seq),  64'h3);
        check("t6_exit_p3", 64'(sim_exit), 64'h0);
        tick();
        check("t6_exit_set", 64'(sim_exit),  64'h1);
        check("t6_drained",  64'(evt_valid), 64'h0);
        evt_ready = 1'b0;
        drive(2'b01, 32'h00602013, 32'h0);
        tick();
        tick();
        drive(2'b00, 32'h0, 32'h0);
        check("t6_requeue",     64'(evt_valid), 64'h1);
        check("t6_exit_sticky", 64'(sim_exit),  64'h1);
        check("t6_seq_after",   64'(evt_seq),   64'h4);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", 64'(evt_valid), 64'h0);
        check("t6_rst_exit",  64'(sim_exit),  64'h0);
        check("t6_rst_phase", 64'(phase),     64'hF);
        tick();
        reset = 1'b1;
        tick();
        check("t6_post_rst_valid", 64'(evt_valid), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
